// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped, write-through, no-write-allocate data cache.
//               2^INDEX_W lines of four 32-bit words, single-word CPU port,
//               line-wide refill port toward data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              mem_miss,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        next_state;

  // Cache storage; only the valid bits need a reset value.
  logic [127:0]      line_data  [LINES];
  logic [TAG_W-1:0]  line_tag   [LINES];
  logic [LINES-1:0]  line_valid;

  // Transaction registers captured when leaving IDLE.
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  // Live CPU address fields.
  logic [1:0]        cpu_off;
  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              hit;

  // Latched address fields, used by the store-hit update and the refill.
  logic [1:0]        lat_off;
  logic [INDEX_W-1:0] lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_hit;

  logic              fill_we;
  logic              store_we;
  logic [31:0]       hit_word;

  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[INDEX_W+1:2];
  assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W+2];
  assign hit     = line_valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
  assign hit_word = line_data[cpu_idx][{cpu_off, 5'b00000} +: 32];

  assign lat_off = lat_addr[1:0];
  assign lat_idx = lat_addr[INDEX_W+1:2];
  assign lat_tag = lat_addr[ADDR_W-1:INDEX_W+2];
  assign lat_hit = line_valid[lat_idx] && (line_tag[lat_idx] == lat_tag);

  // Cache writes happen only on the completion pulse of an active
  // transaction; reset forces IDLE, so an aborted one never writes.
  assign fill_we  = (state == FILL) && mem_ready;
  assign store_we = (state == WRITE) && mem_ready && lat_hit;

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; stores win over loads in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          next_state = WRITE;
        end else if (cpu_rd && !hit) begin
          next_state = FILL;
        end
      end
      FILL:    if (mem_ready) next_state = IDLE;
      WRITE:   if (mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: memory side comes from state and latched registers only.
  always_comb begin
    cpu_rdata = 32'h0;
    stall     = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_miss  = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (RST) begin
          stall = cpu_wr || (cpu_rd && !hit);
          if (cpu_rd && !cpu_wr && hit) begin
            cpu_rdata = hit_word;
          end
        end
      end
      FILL: begin
        stall     = 1'b1;
        mem_rd_en = 1'b1;
        mem_miss  = 1'b1;
        mem_addr  = lat_addr;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      default: begin
        // DONE: one stall-free cycle lets the CPU retire the store.
      end
    endcase
  end

  // Capture the transaction in IDLE; a refill always starts at word 0.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
    end else if (state == IDLE) begin
      if (cpu_wr) begin
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end else if (cpu_rd && !hit) begin
        lat_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

  // Valid bits: cleared by reset, set when a refill completes.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      line_valid <= '0;
    end else if (fill_we) begin
      line_valid[lat_idx] <= 1'b1;
    end
  end

  // Line data and tags: whole-line refill, or single-word store-hit update.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data[lat_idx] <= mem_rdata;
      line_tag[lat_idx]  <= lat_tag;
    end else if (store_we) begin
      line_data[lat_idx][{lat_off, 5'b00000} +: 32] <= lat_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Directed self-checking bench for data_cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  logic         clk;
  logic         RST;
  logic         cpu_rd;
  logic         cpu_wr;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_rd_en;
  logic         mem_wr_en;
  logic         mem_miss;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int compared;
  int mismatched;

  data_cache #(.ADDR_W(10), .INDEX_W(5)) dut (
    .clk       (clk),
    .RST       (RST),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_miss  (mem_miss),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RST        = 1'b0;
    cpu_rd     = 1'b1;
    cpu_wr     = 1'b0;
    cpu_addr   = 10'h004;
    cpu_wdata  = 32'h0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;

    // Reset held with a load pending: everything quiet.
    sample();
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
    chk("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("rst_addr", {22'b0, mem_addr}, 32'h0);

    // Cold load of 0x004.
    next_edge();
    RST = 1'b1;
    sample();
    chk("cold_idle_stall", {31'b0, stall}, 32'h1);
    chk("cold_idle_rd_en", {31'b0, mem_rd_en}, 32'h0);
    next_edge();
    sample();
    chk("cold_fill_rd_en", {31'b0, mem_rd_en}, 32'h1);
    chk("cold_fill_miss", {31'b0, mem_miss}, 32'h1);
    chk("cold_fill_addr", {22'b0, mem_addr}, 32'h004);
    chk("cold_fill_stall", {31'b0, stall}, 32'h1);
    chk("cold_fill_wr_en", {31'b0, mem_wr_en}, 32'h0);
    next_edge();
    sample();
    chk("cold_fill_wait", {31'b0, mem_rd_en}, 32'h1);
    mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
    mem_ready = 1'b1;
    next_edge();
    mem_ready = 1'b0;
    sample();
    chk("cold_hit_rdata", cpu_rdata, 32'hA);
    chk("cold_hit_stall", {31'b0, stall}, 32'h0);
    chk("cold_hit_rd_en", {31'b0, mem_rd_en}, 32'h0);

    // Same-line load of 0x006 hits immediately.
    next_edge();
    cpu_addr = 10'h006;
    sample();
    chk("same_rdata", cpu_rdata, 32'hC);
    chk("same_stall", {31'b0, stall}, 32'h0);
    chk("same_rd_en", {31'b0, mem_rd_en}, 32'h0);

    // Store hit to 0x005, with load also raised: store has priority.
    next_edge();
    cpu_wr    = 1'b1;
    cpu_addr  = 10'h005;
    cpu_wdata = 32'h1234;
    sample();
    chk("prio_rdata", cpu_rdata, 32'h0);
    chk("prio_stall", {31'b0, stall}, 32'h1);
    next_edge();
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = 10'h3FF;
    cpu_wdata = 32'hFFFF;
    sample();
    chk("sthit_wr_en", {31'b0, mem_wr_en}, 32'h1);
    chk("sthit_rd_en", {31'b0, mem_rd_en}, 32'h0);
    chk("sthit_addr", {22'b0, mem_addr}, 32'h005);
    chk("sthit_wdata", mem_wdata, 32'h1234);
    chk("sthit_stall", {31'b0, stall}, 32'h1);
    next_edge();
    sample();
    chk("sthit_hold", {31'b0, mem_wr_en}, 32'h1);
    mem_ready = 1'b1;
    next_edge();
    mem_ready = 1'b0;
    sample();
    chk("done_stall", {31'b0, stall}, 32'h0);
    chk("done_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("done_addr", {22'b0, mem_addr}, 32'h0);
    chk("done_wdata", mem_wdata, 32'h0);
    next_edge();
    cpu_rd   = 1'b1;
    cpu_addr = 10'h005;
    sample();
    chk("sthit_reload", cpu_rdata, 32'h1234);
    chk("sthit_reload_stall", {31'b0, stall}, 32'h0);
    next_edge();
    cpu_addr = 10'h004;
    sample();
    chk("sthit_neighbour", cpu_rdata, 32'hA);

    // Store miss to 0x3F0: memory written, no allocation.
    next_edge();
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 10'h3F0;
    cpu_wdata = 32'hCAFE;
    sample();
    chk("stmiss_stall", {31'b0, stall}, 32'h1);
    next_edge();
    cpu_wr = 1'b0;
    sample();
    chk("stmiss_wr_en", {31'b0, mem_wr_en}, 32'h1);
    chk("stmiss_addr", {22'b0, mem_addr}, 32'h3F0);
    chk("stmiss_wdata", mem_wdata, 32'hCAFE);
    mem_ready = 1'b1;
    next_edge();
    mem_ready = 1'b0;
    sample();
    chk("stmiss_done_stall", {31'b0, stall}, 32'h0);
    next_edge();
    cpu_rd   = 1'b1;
    cpu_addr = 10'h3F0;
    sample();
    chk("stmiss_load_stall", {31'b0, stall}, 32'h1);
    chk("stmiss_load_rdata", cpu_rdata, 32'h0);
    next_edge();
    sample();
    chk("stmiss_fill_rd_en", {31'b0, mem_rd_en}, 32'h1);
    chk("stmiss_fill_addr", {22'b0, mem_addr}, 32'h3F0);
    mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
    mem_ready = 1'b1;
    next_edge();
    mem_ready = 1'b0;
    sample();
    chk("stmiss_fill_rdata", cpu_rdata, 32'h1);
    chk("stmiss_fill_stall", {31'b0, stall}, 32'h0);

    // Conflict: 0x086 shares index 1 with 0x004, different tag.
    next_edge();
    cpu_addr = 10'h086;
    sample();
    chk("conf_stall", {31'b0, stall}, 32'h1);
    next_edge();
    sample();
    chk("conf_fill_addr", {22'b0, mem_addr}, 32'h084);
    mem_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
    mem_ready = 1'b1;
    next_edge();
    mem_ready = 1'b0;
    sample();
    chk("conf_rdata", cpu_rdata, 32'h7);
    next_edge();
    cpu_addr = 10'h004;
    sample();
    chk("conf_evict_stall", {31'b0, stall}, 32'h1);
    chk("conf_evict_rdata", cpu_rdata, 32'h0);

    // Reset pulsed during the refill of 0x004 aborts it.
    next_edge();
    sample();
    chk("abort_fill_rd_en", {31'b0, mem_rd_en}, 32'h1);
    mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
    mem_ready = 1'b1;
    RST       = 1'b0;
    #1;
    chk("abort_rd_en", {31'b0, mem_rd_en}, 32'h0);
    chk("abort_miss", {31'b0, mem_miss}, 32'h0);
    chk("abort_stall", {31'b0, stall}, 32'h0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    next_edge();
    mem_ready = 1'b0;
    RST       = 1'b1;
    sample();
    chk("abort_reload_stall", {31'b0, stall}, 32'h1);
    chk("abort_reload_rdata", cpu_rdata, 32'h0);
    next_edge();
    sample();
    chk("abort_refill_addr", {22'b0, mem_addr}, 32'h004);
    cpu_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
